fmrv32im_alu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared fmrv32im ALU. It accepts encoded ALU operations from two independent requesters (main pipeline and auxiliary address/debug path) over valid/ready handshakes, grants one at a time, and drives the ALU's one-hot instruction lines and operands for exactly one cycle. It captures the registered ALU result and returns it with requester ID and error flag over a back-pressured response channel. It sits between the decode/issue logic and the ALU; only one operation is in flight at a time.

---
 rtl/fmrv32im_alu_pkg.sv | 48 ++++
 rtl/fmrv32im_alu_opdec.sv | 20 ++
 rtl/fmrv32im_alu_arb.sv | 156 +++++++++++++++
 tb/tb_fmrv32im_alu_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmrv32im_alu_pkg.sv
// Shared definitions for the fmrv32im ALU arbiter: op codes and FSM states.
package fmrv32im_alu_pkg;

    localparam int ALU_OP_W   = 6;
    localparam int ALU_OP_NUM = 33;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDI  = 6'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTI  = 6'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTIU = 6'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XORI  = 6'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ORI   = 6'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ANDI  = 6'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLLI  = 6'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRLI  = 6'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRAI  = 6'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 6'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 6'd10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL   = 6'd11;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT   = 6'd12;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU  = 6'd13;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR   = 6'd14;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL   = 6'd15;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA   = 6'd16;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 6'd17;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 6'd18;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BEQ   = 6'd19;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BNE   = 6'd20;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BLT   = 6'd21;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BGE   = 6'd22;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BLTU  = 6'd23;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BGEU  = 6'd24;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LB    = 6'd25;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LH    = 6'd26;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LW    = 6'd27;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LBU   = 6'd28;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LHU   = 6'd29;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SB    = 6'd30;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SH    = 6'd31;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SW    = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } alu_arb_state_t;

endpackage

// File: rtl/fmrv32im_alu_opdec.sv
// Op code to one-hot ALU instruction decoder; codes past SW are flagged illegal.
module fmrv32im_alu_opdec
    import fmrv32im_alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   i_op,
    output logic [ALU_OP_NUM-1:0] o_inst,
    output logic                  o_illegal
);

    // One-hot expansion; illegal codes leave every instruction line low.
    always_comb begin
        o_inst    = '0;
        o_illegal = 1'b1;
        if (int'(i_op) < ALU_OP_NUM) begin
            o_inst[i_op] = 1'b1;
            o_illegal    = 1'b0;
        end
    end

endmodule

// File: rtl/fmrv32im_alu_arb.sv
// Two-requester arbiter/sequencer for the shared fmrv32im ALU.
// One op in flight: IDLE (grant) -> ISSUE (INST pulse) -> WAIT (capture) -> RESP.
// Build option: FMRV_ALU_ARB_RR_EN selects round-robin instead of fixed
// priority to requester 0.
module fmrv32im_alu_arb
    import fmrv32im_alu_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ0_VALID,
    output logic                  REQ0_READY,
    input  logic [ALU_OP_W-1:0]   REQ0_OP,
    input  logic [31:0]           REQ0_RS1,
    input  logic [31:0]           REQ0_RS2,
    input  logic [31:0]           REQ0_IMM,
    input  logic                  REQ1_VALID,
    output logic                  REQ1_READY,
    input  logic [ALU_OP_W-1:0]   REQ1_OP,
    input  logic [31:0]           REQ1_RS1,
    input  logic [31:0]           REQ1_RS2,
    input  logic [31:0]           REQ1_IMM,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_ID,
    output logic [31:0]           RSP_DATA,
    output logic                  RSP_ERR,
    output logic [ALU_OP_NUM-1:0] ALU_INST,
    output logic [31:0]           ALU_RS1,
    output logic [31:0]           ALU_RS2,
    output logic [31:0]           ALU_IMM,
    input  logic                  ALU_RSLT_VALID,
    input  logic [31:0]           ALU_RSLT
);

    alu_arb_state_t        r_state;
    logic [ALU_OP_NUM-1:0] r_inst;
    logic                  r_illegal;
    logic                  r_id;
    logic [31:0]           r_rs1;
    logic [31:0]           r_rs2;
    logic [31:0]           r_imm;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_data;
    logic                  r_rsp_err;

    logic                  w_win;
    logic                  w_idle;
    logic                  w_grant;
    logic [ALU_OP_W-1:0]   w_op;
    logic [ALU_OP_NUM-1:0] w_dec_inst;
    logic                  w_dec_illegal;

`ifdef FMRV_ALU_ARB_RR_EN
    logic                  r_last;

    // Winner: alternate on contention, otherwise whoever is asking.
    always_comb begin
        w_win = REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
            w_win = ~r_last;
        end
    end

    // Last-served pointer moves only when an op is actually granted.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`else
    // Winner: requester 0 always has priority.
    always_comb begin
        w_win = ~REQ0_VALID;
    end
`endif

    // READY is gated by RST_N so nothing is accepted while reset is asserted.
    assign w_idle     = (r_state == ST_IDLE) && RST_N;
    assign REQ0_READY = w_idle && REQ0_VALID && !w_win;
    assign REQ1_READY = w_idle && REQ1_VALID && w_win;
    assign w_grant    = REQ0_READY || REQ1_READY;
    assign w_op       = w_win ? REQ1_OP : REQ0_OP;

    // Decode at grant time so ALU_INST comes straight from a register in ISSUE.
    fmrv32im_alu_opdec u_opdec (
        .i_op      (w_op),
        .o_inst    (w_dec_inst),
        .o_illegal (w_dec_illegal)
    );

    // Sequencer FSM: latch on grant, pulse INST once, capture result, hold response.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_inst      <= '0;
            r_illegal   <= 1'b0;
            r_id        <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_id      <= w_win;
                        r_rs1     <= w_win ? REQ1_RS1 : REQ0_RS1;
                        r_rs2     <= w_win ? REQ1_RS2 : REQ0_RS2;
                        r_imm     <= w_win ? REQ1_IMM : REQ0_IMM;
                        r_inst    <= w_dec_inst;
                        r_illegal <= w_dec_illegal;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_inst  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_rsp_valid <= 1'b1;
                    if (ALU_RSLT_VALID && !r_illegal) begin
                        r_rsp_data <= ALU_RSLT;
                        r_rsp_err  <= 1'b0;
                    end else begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign RSP_VALID = r_rsp_valid;
    assign RSP_ID    = r_id;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ERR   = r_rsp_err;
    assign ALU_INST  = r_inst;
    assign ALU_RS1   = r_rs1;
    assign ALU_RS2   = r_rs2;
    assign ALU_IMM   = r_imm;

endmodule

// File: tb/tb_fmrv32im_alu_arb.sv
// Bench for fmrv32im_alu_arb: a behavioural ALU answers INST pulses one cycle
// later; expected responses come from an op-code level reference function.
module tb_fmrv32im_alu_arb;
    import fmrv32im_alu_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        REQ0_VALID, REQ1_VALID;
    logic        REQ0_READY, REQ1_READY;
    logic [5:0]  REQ0_OP, REQ1_OP;
    logic [31:0] REQ0_RS1, REQ0_RS2, REQ0_IMM;
    logic [31:0] REQ1_RS1, REQ1_RS2, REQ1_IMM;
    logic        RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
    logic [31:0] RSP_DATA;
    logic [32:0] ALU_INST;
    logic [31:0] ALU_RS1, ALU_RS2, ALU_IMM;
    logic        ALU_RSLT_VALID;
    logic [31:0] ALU_RSLT;

    logic        alu_vld;
    logic [31:0] alu_res;
    logic        inj_vld;
    int          checks;
    int          failures;
    int          cyc;

    fmrv32im_alu_arb dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
        .REQ0_RS1(REQ0_RS1), .REQ0_RS2(REQ0_RS2), .REQ0_IMM(REQ0_IMM),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
        .REQ1_RS1(REQ1_RS1), .REQ1_RS2(REQ1_RS2), .REQ1_IMM(REQ1_IMM),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .ALU_INST(ALU_INST), .ALU_RS1(ALU_RS1), .ALU_RS2(ALU_RS2), .ALU_IMM(ALU_IMM),
        .ALU_RSLT_VALID(ALU_RSLT_VALID), .ALU_RSLT(ALU_RSLT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference semantics of every legal op code.
    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] i);
        case (op)
            ALU_OP_ADDI:  return a + i;
            ALU_OP_SLTI:  return {31'd0, $signed(a) < $signed(i)};
            ALU_OP_SLTIU: return {31'd0, a < i};
            ALU_OP_XORI:  return a ^ i;
            ALU_OP_ORI:   return a | i;
            ALU_OP_ANDI:  return a & i;
            ALU_OP_SLLI:  return a << i[4:0];
            ALU_OP_SRLI:  return a >> i[4:0];
            ALU_OP_SRAI:  return $unsigned($signed(a) >>> i[4:0]);
            ALU_OP_ADD:   return a + b;
            ALU_OP_SUB:   return a - b;
            ALU_OP_SLL:   return a << b[4:0];
            ALU_OP_SLT:   return {31'd0, $signed(a) < $signed(b)};
            ALU_OP_SLTU:  return {31'd0, a < b};
            ALU_OP_XOR:   return a ^ b;
            ALU_OP_SRL:   return a >> b[4:0];
            ALU_OP_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            ALU_OP_OR:    return a | b;
            ALU_OP_AND:   return a & b;
            ALU_OP_BEQ:   return {31'd0, a == b};
            ALU_OP_BNE:   return {31'd0, a != b};
            ALU_OP_BLT:   return {31'd0, $signed(a) < $signed(b)};
            ALU_OP_BGE:   return {31'd0, $signed(a) >= $signed(b)};
            ALU_OP_BLTU:  return {31'd0, a < b};
            ALU_OP_BGEU:  return {31'd0, a >= b};
            default:      return a + i;   // loads/stores: effective address
        endcase
    endfunction

    // Behavioural ALU: registered result one cycle after an INST line is seen.
    always @(posedge CLK) begin
        alu_vld <= 1'b0;
        alu_res <= 32'h0;
        for (int k = 0; k < 33; k++) begin
            if (ALU_INST[k]) begin
                alu_vld <= 1'b1;
                alu_res <= alu_ref(6'(k), ALU_RS1, ALU_RS2, ALU_IMM);
            end
        end
    end
    assign ALU_RSLT_VALID = alu_vld | inj_vld;
    assign ALU_RSLT       = alu_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from requester id; hold = RSP_READY-low cycles.
    task automatic do_op(input string tag, input bit id, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                         input int hold, input bit inj);
        logic [31:0] exp_d;
        logic        exp_e;
        logic [32:0] exp_inst;
        bit          got;
        exp_e    = (op > 6'd32);
        exp_d    = exp_e ? 32'h0 : alu_ref(op, a, b, i);
        exp_inst = exp_e ? 33'h0 : (33'd1 << op);
        if (id) begin
            REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_RS1 = a; REQ1_RS2 = b; REQ1_IMM = i;
        end else begin
            REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_RS1 = a; REQ0_RS2 = b; REQ0_IMM = i;
        end
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (id ? REQ1_READY : REQ0_READY) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        chk({tag, "_grant"}, got, 1'b1);
        chk({tag, "_other_ready"}, id ? REQ0_READY : REQ1_READY, 1'b0);
        // T+1: drop request, scramble operands, expect one INST pulse
        @(negedge CLK);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_RS1 = $urandom; REQ1_RS1 = $urandom; REQ0_RS2 = $urandom; REQ1_RS2 = $urandom;
        if (inj) inj_vld = 1'b1;
        #1;
        chk({tag, "_inst"}, ALU_INST, exp_inst);
        chk({tag, "_rs1"}, ALU_RS1, a);
        chk({tag, "_rs2"}, ALU_RS2, b);
        chk({tag, "_imm"}, ALU_IMM, i);
        // T+2: INST gone, no response yet
        @(negedge CLK);
        inj_vld = 1'b0;
        #1;
        chk({tag, "_inst_off"}, ALU_INST, 33'h0);
        chk({tag, "_rsp_early"}, RSP_VALID, 1'b0);
        // T+3: response
        @(negedge CLK);
        #1;
        chk({tag, "_rsp_valid"}, RSP_VALID, 1'b1);
        chk({tag, "_rsp_id"}, RSP_ID, id);
        chk({tag, "_rsp_data"}, RSP_DATA, exp_d);
        chk({tag, "_rsp_err"}, RSP_ERR, exp_e);
        if (hold > 0) begin
            REQ0_VALID = 1'b1; REQ0_OP = ALU_OP_ADDI;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            #1;
            chk({tag, "_hold_valid"}, RSP_VALID, 1'b1);
            chk({tag, "_hold_data"}, RSP_DATA, exp_d);
            chk({tag, "_hold_id_err"}, {RSP_ID, RSP_ERR}, {id, exp_e});
            chk({tag, "_hold_ready"}, REQ0_READY, 1'b0);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        #1;
        chk({tag, "_rsp_done"}, RSP_VALID, 1'b0);
        if (hold > 0) begin
            chk({tag, "_ready_after"}, REQ0_READY, 1'b1);
            REQ0_VALID = 1'b0;
        end
        RSP_READY = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int          exp_id;
        int          last;
        int          prev;
        bit          got;
        bit          seen;
        logic [5:0]  rop;
        checks = 0; failures = 0; cyc = 0; inj_vld = 1'b0;
        RST_N = 1'b0; RSP_READY = 1'b0;
        REQ0_VALID = 1'b0; REQ0_OP = '0; REQ0_RS1 = '0; REQ0_RS2 = '0; REQ0_IMM = '0;
        REQ1_VALID = 1'b0; REQ1_OP = '0; REQ1_RS1 = '0; REQ1_RS2 = '0; REQ1_IMM = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ready", {REQ0_READY, REQ1_READY}, 2'b00);
        chk("rst_rsp", {RSP_VALID, RSP_ID, RSP_ERR}, 3'b000);
        chk("rst_data", RSP_DATA, 32'h0);
        chk("rst_inst", ALU_INST, 33'h0);
        chk("rst_ops", {ALU_RS1, ALU_RS2}, 64'h0);
        chk("rst_imm", ALU_IMM, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        do_op("add", 1'b0, ALU_OP_ADD, 32'd5, 32'd7, 32'd0, 0, 1'b0);
        do_op("illegal", 1'b1, 6'd40, 32'h1234, 32'h5678, 32'h9, 0, 1'b0);
        do_op("illegal_inj", 1'b0, 6'd33, 32'h1, 32'h2, 32'h3, 0, 1'b1);
        do_op("sltu_hold", 1'b0, ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 5, 1'b0);
        do_op("bge", 1'b1, ALU_OP_BGE, 32'hFFFF_FFFE, 32'd3, 32'd0, 0, 1'b0);
        do_op("bgeu", 1'b0, ALU_OP_BGEU, 32'hFFFF_FFFE, 32'd3, 32'd0, 0, 1'b0);
        do_op("sw", 1'b1, ALU_OP_SW, 32'h1000, 32'h0, 32'h24, 1, 1'b0);

        // Arbitration under continuous contention.
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        REQ0_OP = ALU_OP_ADDI; REQ1_OP = ALU_OP_ADDI;
        REQ0_IMM = 32'd1; REQ1_IMM = 32'd1;
        RSP_READY = 1'b1;
        last = 1; prev = 0;
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int w = 0; w < 10; w++) begin
                #1;
                if (REQ0_READY || REQ1_READY) begin got = 1'b1; break; end
                @(negedge CLK);
            end
            chk("arb_grant", got, 1'b1);
            if (!got) break;
            chk("arb_onehot", REQ0_READY & REQ1_READY, 1'b0);
`ifdef FMRV_ALU_ARB_RR_EN
            exp_id = (last == 1) ? 0 : 1;
`else
            exp_id = 0;
`endif
            chk("arb_id", REQ1_READY, exp_id[0]);
            last = exp_id;
            if (k > 0) chk("arb_spacing", cyc - prev, 4);
            prev = cyc;
            @(negedge CLK);
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        RSP_READY = 1'b0;

        // Reset while the op sits in WAIT.
        REQ0_VALID = 1'b1; REQ0_OP = ALU_OP_ADD; REQ0_RS1 = 32'd5; REQ0_RS2 = 32'd7;
        #1;
        chk("rstmid_grant", REQ0_READY, 1'b1);
        @(negedge CLK);
        REQ0_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        chk("rstmid_rsp", RSP_VALID, 1'b0);
        chk("rstmid_inst", ALU_INST, 33'h0);
        chk("rstmid_ops", ALU_RS1, 32'h0);
        RST_N = 1'b1;
        RSP_READY = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 6; w++) begin
            @(negedge CLK);
            #1;
            if (RSP_VALID) seen = 1'b1;
        end
        chk("rstmid_no_rsp", seen, 1'b0);
        RSP_READY = 1'b0;
        @(negedge CLK);
        do_op("after_rst", 1'b1, ALU_OP_SUB, 32'd100, 32'd58, 32'd0, 0, 1'b0);

        // Randomized operations against the reference.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(33, 63));
            else rop = 6'($urandom_range(0, 32));
            do_op("rand", 1'($urandom_range(0, 1)), rop, $urandom, $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                  $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the run wedges somewhere.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
